// File: rtl/imem_loader.sv
// Byte-stream program loader for the tinyml_risc_cpu instruction memory.
// Assembles little-endian words, adds even parity, and holds the CPU until a full image is written.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wparity,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       count;
  logic [1:0]        byte_idx;
  logic [23:0]       word_lo;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              last_word;
  logic              hdr_bad;

  function automatic logic even_parity(input logic [31:0] w);
    return ^w;
  endfunction

  assign accept    = s_valid && s_ready;
  assign last_word = (16'(words_loaded) + 16'd1) == count;
  assign hdr_bad   = ({s_data, count[7:0]} == 16'd0) || ({s_data, count[7:0]} > 16'(DEPTH));

  // All status outputs are pure decodes of the state register, so they never depend on s_valid.
  assign s_ready  = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign mem_we   = (state == WRITE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign cpu_hold = (state != DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = HDR0;
        else       state_nxt = state;
      end
      HDR0: begin
        if (accept) state_nxt = HDR1;
        else        state_nxt = state;
      end
      HDR1: begin
        if (accept && hdr_bad)  state_nxt = ERR;
        else if (accept)        state_nxt = DATA;
        else                    state_nxt = state;
      end
      DATA: begin
        if (accept && (byte_idx == 2'd3)) state_nxt = WRITE;
        else                              state_nxt = state;
      end
      WRITE: begin
        if (last_word) state_nxt = DONE;
        else           state_nxt = DATA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: header capture, word assembly, and the registered memory write port
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= 16'd0;
      byte_idx     <= 2'd0;
      word_lo      <= 24'd0;
      addr         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      mem_wparity  <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) words_loaded <= '0;
        end
        HDR0: begin
          if (accept) count[7:0] <= s_data;
        end
        HDR1: begin
          if (accept) begin
            count[15:8] <= s_data;
            byte_idx    <= 2'd0;
            addr        <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= s_data;
              2'd1: word_lo[15:8]  <= s_data;
              2'd2: word_lo[23:16] <= s_data;
              default: begin
                // Write port only moves when a complete word is ready, so it is stable in WRITE.
                mem_wdata   <= {s_data, word_lo};
                mem_wparity <= even_parity({s_data, word_lo});
                mem_addr    <= addr;
              end
            endcase
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          if (!last_word) addr <= addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: inputs driven and outputs sampled on the falling edge.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wparity;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  bit bp_mode = 1'b0;

  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic        log_par[$];

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wparity(mem_wparity), .cpu_hold(cpu_hold), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write monitor: every WRITE cycle is logged and must not be accepting bytes
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_par.push_back(mem_wparity);
      check("ready_in_write", {63'd0, s_ready}, 64'd0);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    if (bp_mode) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 64'd1, 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("end_timeout", 64'd1, 64'd0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_par.delete();
  endtask

  task automatic check_write(input int idx, input logic [5:0] a, input logic [31:0] d, input logic p);
    if (log_addr.size() > idx) begin
      check("wr_addr", 64'(log_addr[idx]), 64'(a));
      check("wr_data", 64'(log_data[idx]), 64'(d));
      check("wr_par",  64'(log_par[idx]),  64'(p));
    end else begin
      check("wr_missing", 64'(log_addr.size()), 64'(idx + 1));
    end
  endtask

  task automatic two_word_load();
    clear_log();
    pulse_start();
    check("ready_after_start", 64'(s_ready), 64'd1);
    send(8'h02); send(8'h00);
    send_word(32'h12345678);
    send_word(32'h00000001);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_data = 8'h00; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_we",    64'(mem_we), 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_wpar",  64'(mem_wparity), 64'd0);
    check("rst_hold",  64'(cpu_hold), 64'd1);
    check("rst_done",  64'(done), 64'd0);
    check("rst_err",   64'(err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);

    // Two-word load with exact latency: last byte at edge t, we in t+1, done in t+2
    two_word_load();
    check("we_t1",    64'(mem_we), 64'd1);
    check("done_t1",  64'(done), 64'd0);
    @(negedge clk);
    check("done_t2",  64'(done), 64'd1);
    check("hold_t2",  64'(cpu_hold), 64'd0);
    check("words_2",  64'(words_loaded), 64'd2);
    check("nwr_2",    64'(log_addr.size()), 64'd2);
    check_write(0, 6'd0, 32'h12345678, 1'b1);
    check_write(1, 6'd1, 32'h00000001, 1'b1);

    // Same stream under random valid gaps
    bp_mode = 1'b1;
    two_word_load();
    bp_mode = 1'b0;
    wait_end();
    check("bp_done",  64'(done), 64'd1);
    check("bp_nwr",   64'(log_addr.size()), 64'd2);
    check_write(0, 6'd0, 32'h12345678, 1'b1);
    check_write(1, 6'd1, 32'h00000001, 1'b1);

    // Illegal headers: zero count and count above depth
    for (int h = 0; h < 2; h++) begin
      clear_log();
      pulse_start();
      send((h == 0) ? 8'h00 : 8'h41);
      send(8'h00);
      check("bad_err",   64'(err), 64'd1);
      check("bad_hold",  64'(cpu_hold), 64'd1);
      check("bad_ready", 64'(s_ready), 64'd0);
      repeat (3) @(negedge clk);
      check("bad_nwr",   64'(log_addr.size()), 64'd0);
    end

    // Recovery from ERR
    clear_log();
    pulse_start();
    check("err_cleared", 64'(err), 64'd0);
    send(8'h01); send(8'h00);
    send_word(32'hDEADBEEF);
    wait_end();
    check("rec_done", 64'(done), 64'd1);
    check("rec_nwr",  64'(log_addr.size()), 64'd1);
    check_write(0, 6'd0, 32'hDEADBEEF, 1'b0);

    // Full depth: 64 words of value i
    clear_log();
    pulse_start();
    send(8'h40); send(8'h00);
    for (int i = 0; i < 64; i++) send_word(32'(i));
    wait_end();
    check("full_done",  64'(done), 64'd1);
    check("full_words", 64'(words_loaded), 64'd64);
    check("full_nwr",   64'(log_addr.size()), 64'd64);
    for (int i = 0; i < 64; i++) check_write(i, 6'(i), 32'(i), ^(6'(i)));
    s_data = 8'hAA; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("extra_ready", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    check("full_nwr_after", 64'(log_addr.size()), 64'd64);

    // Reset after two data bytes of word 0
    clear_log();
    pulse_start();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_ready", 64'(s_ready), 64'd0);
    check("mid_hold",  64'(cpu_hold), 64'd1);
    check("mid_done",  64'(done), 64'd0);
    repeat (4) @(negedge clk);
    check("mid_ready_idle", 64'(s_ready), 64'd0);
    check("mid_nwr",   64'(log_addr.size()), 64'd0);
    pulse_start();
    send(8'h01); send(8'h00);
    send_word(32'hFFFFFFFF);
    wait_end();
    check("ff_nwr", 64'(log_addr.size()), 64'd1);
    check_write(0, 6'd0, 32'hFFFFFFFF, 1'b0);

    // Reload from DONE, with a start pulse during DATA that must be ignored
    clear_log();
    pulse_start();
    check("rl_hold",  64'(cpu_hold), 64'd1);
    check("rl_done",  64'(done), 64'd0);
    check("rl_words", 64'(words_loaded), 64'd0);
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    pulse_start();
    send(8'h33); send(8'h44);
    wait_end();
    check("rl_done_end", 64'(done), 64'd1);
    check("rl_words_end", 64'(words_loaded), 64'd1);
    check("rl_nwr", 64'(log_addr.size()), 64'd1);
    check_write(0, 6'd0, 32'h44332211, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the tinyml_risc_cpu instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. For each word it generates the even-parity bit that the CPU fetch path checks, then writes the word and its parity bit into instruction memory at sequential addresses. It holds the CPU core in reset through `cpu_hold` until a complete program has been written, so fetch never observes a partially loaded image.

## Interface

Parameters:
- `DEPTH`, default 64: instruction memory depth in words. This is the maximum program length.
- `ADDR_W`, default 6: memory address width. Must satisfy 2^ADDR_W >= DEPTH.

Ports (reset `rst` is synchronous, active-high; clock is `clk`):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load. Sampled in IDLE, DONE and ERR only.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a byte. Decoded from the state register only, with no dependence on `s_valid`.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  instruction word.
- `mem_wparity`  out  1  even-parity bit, equal to XOR of all 32 bits of `mem_wdata`.
- `cpu_hold`  out  1  when high, the CPU is held in reset. Tied into `cpu_top` reset as OR with `rst`.
- `done`  out  1  program loaded. Level output, held until the next `start` or `rst`.
- `err`  out  1  illegal header. Level output, held until the next `start` or `rst`.
- `words_loaded`  out  ADDR_W+1  number of words written in the current load.

## Operation

- The stream format is: count low byte, count high byte (16-bit word count N), then 4·N data bytes. Within each word, the first byte maps to bits [7:0] and the fourth byte to bits [31:24].
- A byte is accepted on any cycle where `s_valid && s_ready` is true.
- States:
  - IDLE: `s_ready`=0. `start` moves to HDR0.
  - HDR0: `s_ready`=1. On accept, count[7:0] is captured; go to HDR1.
  - HDR1: `s_ready`=1. On accept, count[15:8] is captured.
    - If N==0 or N>DEPTH, go to ERR.
    - Otherwise clear the byte index and address, then go to DATA.
  - DATA: `s_ready`=1. On accept, the byte is placed at lane byte_idx, then byte_idx is incremented. After the 4th byte, go to WRITE.
  - WRITE: `s_ready`=0 and `mem_we`=1 for exactly one cycle, with `mem_addr`=addr and `mem_wparity`=^word. Then addr and `words_loaded` increment.
    - If this was word N-1, go to DONE.
    - Otherwise go to DATA.
  - DONE: `done`=1, `cpu_hold`=0. `start` moves to HDR0.
  - ERR: `err`=1, `cpu_hold`=1, and memory is untouched. `start` moves to HDR0.
- On any `start` taken, `done` and `err` are cleared, `cpu_hold` is set to 1, and `words_loaded` is set to 0.
- `start` pulses are ignored in HDR0, HDR1, DATA and WRITE.
- `cpu_hold` is 1 in every state except DONE.
- Header bytes never cause a memory write.
- The address never wraps. The last written address is N-1, and N-1 <= DEPTH-1.

## Timing

- Reset values: state IDLE, `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wparity`=0, `cpu_hold`=1, `done`=0, `err`=0, `words_loaded`=0.
- `rst` mid-load: returns to IDLE on the next edge. The partial word is discarded, no write is issued, and `cpu_hold`=1.
- Throughput and latency:
  - At best, 4 bytes are accepted in 4 cycles, followed by 1 WRITE cycle, giving 5 cycles per word.
  - The 4th byte of a word is accepted at edge t. `mem_we` is high during cycle t+1.
  - For the last word, `done`=1 and `cpu_hold`=0 from edge t+2.
- `start` taken at edge t gives `s_ready`=1 from cycle t+1.
- The second header byte accepted at edge t gives `err`=1 from cycle t+1 when the header is illegal.
- `mem_addr`, `mem_wdata` and `mem_wparity` are registered. They are stable throughout the cycle where `mem_we` is high and hold their last values otherwise.
- A gap in `s_valid` stalls the current state indefinitely and loses no data.

## Test plan

- Two-word load: `start`, then bytes 02 00 78 56 34 12 01 00 00 00.
  - Expect write addr 0 = 0x12345678 with parity 1, then write addr 1 = 0x00000001 with parity 1.
  - Expect `done`=1 and `cpu_hold`=0 two cycles after the last byte, and `words_loaded`=2.
- Backpressure: the same stream with `s_valid` randomly deasserted.
  - Expect identical writes.
  - Expect `s_ready`=0 in every WRITE cycle, and no byte dropped or duplicated.
- Illegal headers:
  - Header 00 00 gives `err`=1, `cpu_hold`=1 and no `mem_we`.
  - Header 41 00 (65 > DEPTH) gives the same.
  - A following `start` plus a valid stream clears `err` and loads correctly.
- Full depth: header 40 00 followed by 64 words of value i, for i = 0..63.
  - Expect the last write at addr 63 and `words_loaded`=64, with no further writes.
  - Extra stream bytes see `s_ready`=0.
- Reset mid-word: `rst` after 2 of the 4 data bytes of word 0.
  - Expect no `mem_we`, state IDLE and `cpu_hold`=1.
  - A fresh one-word load of 0xFFFFFFFF writes addr 0 with parity 0.
- Reload from DONE: `start` while in DONE.
  - Expect `cpu_hold`=1 and `done`=0 on the next cycle.
  - Expect the new program to overwrite from addr 0.
  - `start` pulses issued during DATA are ignored.
